// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// sequencer states and the shadow-scoreboard slot record.
package hazard_pkg;

  // Slot rd storage width; decode addresses are zero-extended into it.
  localparam int unsigned RD_MAX_W = 8;

  typedef enum logic [2:0] {
    FWD_RF      = 3'b000,
    FWD_EX      = 3'b001,
    FWD_MEM_ALU = 3'b010,
    FWD_MEM_LD  = 3'b011,
    FWD_WB      = 3'b100
  } fwd_sel_e;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                writes;
    logic                is_load;
    logic                mem_access;
  } slot_t;

  // x0 is hard-wired, so a slot targeting it never produces a value.
  function automatic logic is_writer(slot_t s);
    return s.valid && s.writes && (s.rd != '0);
  endfunction

endpackage

// File: rtl/forward_select_unit.sv
// Per-operand forwarding select: compares one decode source against the
// EX/MEM/WB slots and flags a load in EX that the operand depends on.
module forward_select_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REGISTER_SIZE = 5
) (
  input  logic                     src_used,
  input  logic [REGISTER_SIZE-1:0] src,
  input  slot_t                    ex_slot,
  input  slot_t                    mem_slot,
  input  slot_t                    wb_slot,
  output fwd_sel_e                 sel_c,
  output logic                     load_use_c
);

  logic [RD_MAX_W-1:0] src_w;
  logic                active;
  logic                ex_hit;
  logic                mem_hit;
  logic                wb_hit;
  logic                unused_slot_bits;

  assign src_w   = RD_MAX_W'(src);
  assign active  = src_used && (src_w != '0);
  assign ex_hit  = is_writer(ex_slot) && (ex_slot.rd == src_w);
  assign mem_hit = is_writer(mem_slot) && (mem_slot.rd == src_w);
  assign wb_hit  = is_writer(wb_slot) && (wb_slot.rd == src_w);

  assign unused_slot_bits = ^{ex_slot.mem_access, mem_slot.mem_access,
                              wb_slot.is_load, wb_slot.mem_access};

  // Youngest producer wins; a load still in EX has no data yet.
  always_comb begin
    sel_c      = FWD_RF;
    load_use_c = 1'b0;
    if (active) begin
      if (ex_hit) begin
        if (ex_slot.is_load) load_use_c = 1'b1;
        else                 sel_c      = FWD_EX;
      end else if (mem_hit) begin
        sel_c = mem_slot.is_load ? FWD_MEM_LD : FWD_MEM_ALU;
      end else if (wb_hit) begin
        sel_c = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central 5-stage pipeline sequencer: stage enables, bubbles, flushes,
// operand forwarding, stall accounting and data-memory timeout detection.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned REGISTER_SIZE = 5,
  parameter int unsigned MEM_TIMEOUT   = 64,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dec_valid,
  input  logic [REGISTER_SIZE-1:0] dec_src1,
  input  logic                     dec_src1_used,
  input  logic [REGISTER_SIZE-1:0] dec_src2,
  input  logic                     dec_src2_used,
  input  logic [REGISTER_SIZE-1:0] dec_dest,
  input  logic                     dec_writes_rd,
  input  logic                     dec_is_load,
  input  logic                     dec_mem_access,
  input  logic                     dec_redirect,
  input  logic                     mem_ready,
  output logic                     f_to_d_enable_ff,
  output logic                     d_to_e_enable_ff,
  output logic                     e_to_m_enable_ff,
  output logic                     m_to_w_enable_ff,
  output logic                     f_to_d_flush,
  output logic                     d_to_e_bubble,
  output logic                     m_to_w_bubble,
  output logic [1:0][2:0]          pipeline_forward_sel,
  output logic [CNT_WIDTH-1:0]     stall_count,
  output logic                     mem_timeout_err
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_e   state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  slot_t       ex_q, mem_q, wb_q, dec_slot;
  fwd_sel_e    sel_rs1, sel_rs2;
  logic        lu_rs1, lu_rs2;
  logic        load_use, mem_block, freeze, at_limit, err_set;

  forward_select_unit #(.REGISTER_SIZE(REGISTER_SIZE)) u_fwd_rs1 (
    .src_used   (dec_src1_used),
    .src        (dec_src1),
    .ex_slot    (ex_q),
    .mem_slot   (mem_q),
    .wb_slot    (wb_q),
    .sel_c      (sel_rs1),
    .load_use_c (lu_rs1)
  );

  forward_select_unit #(.REGISTER_SIZE(REGISTER_SIZE)) u_fwd_rs2 (
    .src_used   (dec_src2_used),
    .src        (dec_src2),
    .ex_slot    (ex_q),
    .mem_slot   (mem_q),
    .wb_slot    (wb_q),
    .sel_c      (sel_rs2),
    .load_use_c (lu_rs2)
  );

  assign pipeline_forward_sel[0] = sel_rs1;
  assign pipeline_forward_sel[1] = sel_rs2;

  assign load_use  = dec_valid && (lu_rs1 || lu_rs2);
  assign mem_block = mem_q.valid && mem_q.mem_access && !mem_ready;
  assign at_limit  = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  assign dec_slot = '{valid:      dec_valid,
                      rd:         RD_MAX_W'(dec_dest),
                      writes:     dec_writes_rd,
                      is_load:    dec_is_load,
                      mem_access: dec_mem_access};

  // Next state and stage controls; MEM wait outranks load-use outranks redirect.
  always_comb begin
    state_d          = state_q;
    wait_d           = '0;
    err_set          = 1'b0;
    freeze           = 1'b0;
    f_to_d_enable_ff = 1'b1;
    d_to_e_enable_ff = 1'b1;
    e_to_m_enable_ff = 1'b1;
    m_to_w_enable_ff = 1'b1;
    f_to_d_flush     = 1'b0;
    d_to_e_bubble    = 1'b0;
    m_to_w_bubble    = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_block) begin
          state_d = MEM_WAIT;
          freeze  = 1'b1;
        end else if (load_use) begin
          f_to_d_enable_ff = 1'b0;
          d_to_e_enable_ff = 1'b0;
          d_to_e_bubble    = 1'b1;
        end else if (dec_valid && dec_redirect) begin
          f_to_d_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) state_d = RUN;
        else           freeze  = 1'b1;
      end
    endcase
    // WB retires during the first frozen cycle and then holds a NOP.
    if (freeze) begin
      f_to_d_enable_ff = 1'b0;
      d_to_e_enable_ff = 1'b0;
      e_to_m_enable_ff = 1'b0;
      m_to_w_enable_ff = 1'b0;
      m_to_w_bubble    = 1'b1;
      err_set          = at_limit;
      wait_d           = at_limit ? wait_q : wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= RUN;
      wait_q          <= '0;
      stall_count     <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if ((!f_to_d_enable_ff || d_to_e_bubble) && (stall_count != '1))
        stall_count <= stall_count + CNT_WIDTH'(1);
      if (err_set) mem_timeout_err <= 1'b1;
    end
  end

  // Shadow scoreboard follows the datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      if (d_to_e_bubble)         ex_q <= '0;
      else if (d_to_e_enable_ff) ex_q <= dec_slot;
      if (e_to_m_enable_ff)      mem_q <= ex_q;
      if (m_to_w_bubble)         wb_q <= '0;
      else if (m_to_w_enable_ff) wb_q <= mem_q;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller (MEM_TIMEOUT = 4).
module tb_pipeline_hazard_controller;

  logic        clk;
  logic        rst;
  logic        dec_valid;
  logic [4:0]  dec_src1;
  logic        dec_src1_used;
  logic [4:0]  dec_src2;
  logic        dec_src2_used;
  logic [4:0]  dec_dest;
  logic        dec_writes_rd;
  logic        dec_is_load;
  logic        dec_mem_access;
  logic        dec_redirect;
  logic        mem_ready;
  logic        f_to_d_enable_ff;
  logic        d_to_e_enable_ff;
  logic        e_to_m_enable_ff;
  logic        m_to_w_enable_ff;
  logic        f_to_d_flush;
  logic        d_to_e_bubble;
  logic        m_to_w_bubble;
  logic [1:0][2:0] pipeline_forward_sel;
  logic [31:0] stall_count;
  logic        mem_timeout_err;

  logic [3:0]  en;
  logic [2:0]  ctl;
  int          checks;
  int          errors;

  assign en  = {f_to_d_enable_ff, d_to_e_enable_ff, e_to_m_enable_ff, m_to_w_enable_ff};
  assign ctl = {f_to_d_flush, d_to_e_bubble, m_to_w_bubble};

  pipeline_hazard_controller #(
    .REGISTER_SIZE(5),
    .MEM_TIMEOUT  (4),
    .CNT_WIDTH    (32)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .dec_valid           (dec_valid),
    .dec_src1            (dec_src1),
    .dec_src1_used       (dec_src1_used),
    .dec_src2            (dec_src2),
    .dec_src2_used       (dec_src2_used),
    .dec_dest            (dec_dest),
    .dec_writes_rd       (dec_writes_rd),
    .dec_is_load         (dec_is_load),
    .dec_mem_access      (dec_mem_access),
    .dec_redirect        (dec_redirect),
    .mem_ready           (mem_ready),
    .f_to_d_enable_ff    (f_to_d_enable_ff),
    .d_to_e_enable_ff    (d_to_e_enable_ff),
    .e_to_m_enable_ff    (e_to_m_enable_ff),
    .m_to_w_enable_ff    (m_to_w_enable_ff),
    .f_to_d_flush        (f_to_d_flush),
    .d_to_e_bubble       (d_to_e_bubble),
    .m_to_w_bubble       (m_to_w_bubble),
    .pipeline_forward_sel(pipeline_forward_sel),
    .stall_count         (stall_count),
    .mem_timeout_err     (mem_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [4:0] s1, input logic u1,
                         input logic [4:0] s2, input logic u2, input logic [4:0] d,
                         input logic w, input logic ld, input logic ma, input logic rdr);
    dec_valid = v;  dec_src1 = s1; dec_src1_used = u1;
    dec_src2 = s2;  dec_src2_used = u2; dec_dest = d;
    dec_writes_rd = w; dec_is_load = ld; dec_mem_access = ma; dec_redirect = rdr;
    #1;
  endtask

  task automatic drain();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_ready = 1'b1;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    rst = 1'b1;
    #1;
    checks++; if (en !== 4'b1111) begin errors++; $display("FAIL rst_en got %b exp 1111", en); end
    checks++; if (ctl !== 3'b000) begin errors++; $display("FAIL rst_ctl got %b exp 000", ctl); end
    checks++; if (pipeline_forward_sel !== 6'b000000) begin errors++; $display("FAIL rst_fwd got %b exp 000000", pipeline_forward_sel); end
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL rst_stall got %0d exp 0", stall_count); end
    checks++; if (mem_timeout_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", mem_timeout_err); end
  endtask

  task automatic test_forward_alu();
    set_dec(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    tick();
    set_dec(1, 5, 1, 0, 0, 7, 1, 0, 0, 0);
    checks++; if (pipeline_forward_sel !== 6'b000_001) begin errors++; $display("FAIL fwd_ex got %b exp 000001", pipeline_forward_sel); end
    tick();
    set_dec(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (pipeline_forward_sel !== 6'b000_010) begin errors++; $display("FAIL fwd_mem got %b exp 000010", pipeline_forward_sel); end
    tick();
    set_dec(1, 5, 1, 7, 1, 0, 0, 0, 0, 0);
    checks++; if (pipeline_forward_sel !== 6'b010_100) begin errors++; $display("FAIL fwd_wb got %b exp 010100", pipeline_forward_sel); end
    checks++; if (en !== 4'b1111) begin errors++; $display("FAIL fwd_en got %b exp 1111", en); end
    tick();
    drain();
  endtask

  task automatic test_forward_priority();
    set_dec(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    tick();
    set_dec(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    tick();
    set_dec(1, 9, 0, 9, 1, 0, 0, 0, 0, 0);
    checks++; if (pipeline_forward_sel !== 6'b001_000) begin errors++; $display("FAIL fwd_prio got %b exp 001000", pipeline_forward_sel); end
    drain();
    set_dec(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    set_dec(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    checks++; if (pipeline_forward_sel !== 6'b000_000) begin errors++; $display("FAIL fwd_x0 got %b exp 000000", pipeline_forward_sel); end
    drain();
  endtask

  task automatic test_load_use();
    set_dec(1, 2, 1, 0, 0, 6, 1, 1, 1, 0);
    tick();
    set_dec(1, 3, 1, 6, 1, 8, 1, 0, 0, 0);
    checks++; if (en !== 4'b0011) begin errors++; $display("FAIL lu_en got %b exp 0011", en); end
    checks++; if (ctl !== 3'b010) begin errors++; $display("FAIL lu_ctl got %b exp 010", ctl); end
    checks++; if (pipeline_forward_sel !== 6'b000_000) begin errors++; $display("FAIL lu_fwd got %b exp 000000", pipeline_forward_sel); end
    tick();
    checks++; if (en !== 4'b1111) begin errors++; $display("FAIL lu_after_en got %b exp 1111", en); end
    checks++; if (pipeline_forward_sel !== 6'b011_000) begin errors++; $display("FAIL lu_fwd_ld got %b exp 011000", pipeline_forward_sel); end
    checks++; if (stall_count !== 32'd1) begin errors++; $display("FAIL lu_stall got %0d exp 1", stall_count); end
    tick();
    drain();
  endtask

  task automatic test_mem_wait();
    set_dec(1, 0, 0, 0, 0, 11, 1, 0, 0, 0);
    tick();
    set_dec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    set_dec(1, 0, 0, 0, 0, 10, 1, 0, 0, 0);
    tick();
    mem_ready = 1'b0;
    set_dec(1, 10, 1, 11, 1, 12, 1, 0, 0, 0);
    checks++; if (en !== 4'b0000) begin errors++; $display("FAIL mw1_en got %b exp 0000", en); end
    checks++; if (ctl !== 3'b001) begin errors++; $display("FAIL mw1_ctl got %b exp 001", ctl); end
    checks++; if (pipeline_forward_sel !== 6'b100_001) begin errors++; $display("FAIL mw1_fwd got %b exp 100001", pipeline_forward_sel); end
    tick();
    set_dec(1, 10, 1, 11, 1, 12, 1, 0, 0, 1);
    checks++; if (en !== 4'b0000) begin errors++; $display("FAIL mw2_en got %b exp 0000", en); end
    checks++; if (ctl !== 3'b001) begin errors++; $display("FAIL mw2_ctl got %b exp 001", ctl); end
    checks++; if (pipeline_forward_sel !== 6'b000_001) begin errors++; $display("FAIL mw2_fwd got %b exp 000001", pipeline_forward_sel); end
    tick();
    set_dec(1, 10, 1, 11, 1, 12, 1, 0, 0, 0);
    checks++; if (en !== 4'b0000) begin errors++; $display("FAIL mw3_en got %b exp 0000", en); end
    tick();
    mem_ready = 1'b1;
    #1;
    checks++; if (en !== 4'b1111) begin errors++; $display("FAIL mw_resume_en got %b exp 1111", en); end
    checks++; if (ctl !== 3'b000) begin errors++; $display("FAIL mw_resume_ctl got %b exp 000", ctl); end
    checks++; if (stall_count !== 32'd4) begin errors++; $display("FAIL mw_stall got %0d exp 4", stall_count); end
    checks++; if (mem_timeout_err !== 1'b0) begin errors++; $display("FAIL mw_err got %b exp 0", mem_timeout_err); end
    tick();
    drain();
  endtask

  task automatic test_redirect();
    set_dec(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    checks++; if (ctl !== 3'b100) begin errors++; $display("FAIL rd_ctl got %b exp 100", ctl); end
    checks++; if (en !== 4'b1111) begin errors++; $display("FAIL rd_en got %b exp 1111", en); end
    tick();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (ctl !== 3'b000) begin errors++; $display("FAIL rd_once got %b exp 000", ctl); end
    set_dec(1, 0, 0, 0, 0, 4, 1, 1, 1, 0);
    tick();
    set_dec(1, 4, 1, 0, 0, 0, 0, 0, 0, 1);
    checks++; if (en !== 4'b0011) begin errors++; $display("FAIL rdlu_en got %b exp 0011", en); end
    checks++; if (ctl !== 3'b010) begin errors++; $display("FAIL rdlu_ctl got %b exp 010", ctl); end
    tick();
    checks++; if (ctl !== 3'b100) begin errors++; $display("FAIL rdlu_flush got %b exp 100", ctl); end
    checks++; if (en !== 4'b1111) begin errors++; $display("FAIL rdlu_after_en got %b exp 1111", en); end
    checks++; if (pipeline_forward_sel !== 6'b000_011) begin errors++; $display("FAIL rdlu_fwd got %b exp 000011", pipeline_forward_sel); end
    checks++; if (stall_count !== 32'd5) begin errors++; $display("FAIL rdlu_stall got %0d exp 5", stall_count); end
    tick();
    drain();
  endtask

  task automatic test_timeout();
    set_dec(1, 0, 0, 0, 0, 13, 1, 1, 1, 0);
    tick();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    mem_ready = 1'b0;
    #1;
    checks++; if (en !== 4'b0000) begin errors++; $display("FAIL to_c1_en got %b exp 0000", en); end
    repeat (3) tick();
    checks++; if (mem_timeout_err !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", mem_timeout_err); end
    tick();
    checks++; if (mem_timeout_err !== 1'b1) begin errors++; $display("FAIL to_set got %b exp 1", mem_timeout_err); end
    tick();
    checks++; if (mem_timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", mem_timeout_err); end
    checks++; if (en !== 4'b0000) begin errors++; $display("FAIL to_wait_en got %b exp 0000", en); end
    mem_ready = 1'b1;
    #1;
    checks++; if (en !== 4'b1111) begin errors++; $display("FAIL to_resume_en got %b exp 1111", en); end
    tick();
    checks++; if (mem_timeout_err !== 1'b1) begin errors++; $display("FAIL to_hold got %b exp 1", mem_timeout_err); end
    checks++; if (stall_count !== 32'd10) begin errors++; $display("FAIL to_stall got %0d exp 10", stall_count); end
    checks++; if (en !== 4'b1111) begin errors++; $display("FAIL to_run_en got %b exp 1111", en); end
    drain();
  endtask

  task automatic test_mid_reset();
    set_dec(1, 0, 0, 0, 0, 14, 1, 0, 0, 0);
    tick();
    set_dec(1, 14, 1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (pipeline_forward_sel !== 6'b000_001) begin errors++; $display("FAIL mr_pre got %b exp 000001", pipeline_forward_sel); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (pipeline_forward_sel !== 6'b000_000) begin errors++; $display("FAIL mr_fwd got %b exp 000000", pipeline_forward_sel); end
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL mr_stall got %0d exp 0", stall_count); end
    checks++; if (mem_timeout_err !== 1'b0) begin errors++; $display("FAIL mr_err got %b exp 0", mem_timeout_err); end
    #1;
    rst = 1'b1;
    tick();
    checks++; if (pipeline_forward_sel !== 6'b000_000) begin errors++; $display("FAIL mr_after got %b exp 000000", pipeline_forward_sel); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_forward_alu();
    test_forward_priority();
    test_load_use();
    test_mem_wait();
    test_redirect();
    test_timeout();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
